mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the bexkat1 pipeline. Sits directly downstream of the execute stage and consumes its registered outputs: ir, pc, result/address, reg/sp write-back controls, sp_data and exc.
- Performs the single data-bus transaction needed by load, store, push, pop, jsr/bsr/rts and exception entry on a Wishbone B4 classic master port.
- Back-pressures execute via stall_o while the bus is busy, then forwards write-back information to the register-file stage.

Parameters:
TIMEOUT, 255, bus cycles to wait for ack/err before aborting a transaction with fault_o
AW, 32, byte address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
ir_i  in  64  instruction from execute
pc_i  in  32  pc from execute
result_i  in  32  execute result (effective address for load/store, ALU value otherwise)
reg_data1_i  in  32  ra value (store/push data)
reg_write_i  in  2  register write enables
sp_write_i  in  2  sp write enables
sp_data_i  in  32  updated sp from execute
exc_i  in  1  exception/interrupt entry in progress
stall_i  in  1  downstream hold
stall_o  out  1  hold request to execute
ir_o  out  64  registered ir
pc_o  out  32  registered pc, or return address for rts
pc_set_o  out  1  redirect for rts
result_o  out  32  write-back value
reg_write_o  out  2  registered reg write enables
sp_write_o  out  2  registered sp write enables
sp_data_o  out  32  registered sp
fault_o  out  1  one-cycle bus error/timeout/misalign pulse
bus_cyc_o  out  1  Wishbone cyc
bus_stb_o  out  1  Wishbone stb
bus_we_o  out  1  Wishbone we
bus_sel_o  out  4  byte selects
bus_adr_o  out  AW-2  word address
bus_dat_o  out  32  write data
bus_dat_i  in  32  read data
bus_ack_i  in  1  Wishbone ack
bus_err_i  in  1  Wishbone err

Behaviour:
- Reset (rst_i low, async): every output 0, state IDLE, timeout counter 0; bus_cyc_o/bus_stb_o drop immediately, including mid-transaction.
- Opcode constants come from bexkat1Def. Type = ir_i[31:28], op = ir_i[27:24].
- Memory ops:
  - T_LOAD: read at result_i.
  - T_STORE: write reg_data1_i at result_i.
  - T_PUSH: write at sp_data_i. Data is reg_data1_i for op 0, pc_i for ops 1/2.
  - T_POP: read at sp_data_i-4. Op 0 goes to result_o; op !=0 (rts) loads pc_o and sets pc_set_o.
  - exc_i=1: write pc_i at sp_data_i, overriding the type decode.
- Width for load/store is op[1:0]: 0 word, 1 halfword, 2 byte, 3 word. Push/pop/exc are always word.
- Byte lanes are big-endian: byte offset 0 maps to bits 31:24, sel 4'b1000. Halfword at offset 0 uses sel 1100, offset 2 uses sel 0011.
- Stores replicate data across lanes. Load data is shifted down and zero-extended.
- Misaligned word (adr[1:0]!=0) or halfword (adr[0]=1): no bus cycle; complete through DONE with fault_o=1, result_o=0, reg_write_o=0.
- FSM:
  - IDLE: a non-memory op with stall_i=0 registers all pass-through outputs next edge with 1-cycle latency and stall_o=0. A memory op (or exc_i) asserts stall_o combinationally, latches the address, data, sel and we, then goes to REQ.
  - REQ: cyc=stb=1 with stable adr/dat/sel/we; stall_o=1; the counter increments each cycle.
    - bus_ack_i: capture read data, drop cyc/stb, go to DONE.
    - bus_err_i, or counter reaching TIMEOUT: drop cyc/stb, set the fault flag, go to DONE.
    - ack and err in the same cycle: err wins.
  - DONE: stall_o=0. If stall_i=0, register outputs (result_o = load data or result_i; fault_o pulse; reg_write_o forced 0 on fault) and return to IDLE. If stall_i=1, hold in DONE.
- stall_i=1 in IDLE: all outputs hold and no new transaction starts.
- Pass-through fields (ir, pc, sp_write, sp_data, reg_write) are captured together with result. pc_set_o=1 only for a completed rts without fault.

Test Plan:
- Word load: result_i=0x100, ack after 3 cycles with dat_i=0xDEADBEEF. Required: adr=0x40, sel=1111, stall_o high 4 cycles, then result_o=0xDEADBEEF and reg_write_o=reg_write_i.
- Byte store: addr 0x103, reg_data1=0x5A. Required: sel=0001, dat_o=0x5A5A5A5A, we=1. Byte load at 0x101 with dat_i=0x11223344 gives result_o=0x22.
- Push then rts:
  - push pc_i=0x2000 at sp_data_i=0x7FFC: writes 0x2000 to adr 0x1FFF.
  - pop-rts with sp_data_i=0x8000: reads 0x7FFC; dat_i=0x2000 gives pc_o=0x2000, pc_set_o=1.
- Errors: bus_err_i on a load gives fault_o pulse, reg_write_o=0. No ack for 255 cycles gives abort with fault_o=1. Halfword load at 0x101 gives fault with no cyc.
- stall_i held 2 cycles in DONE: outputs unchanged, stall_o=0, and only one bus cycle is issued.
- rst_i low during REQ: cyc/stb go low asynchronously; after release, state is IDLE and outputs are 0.

Source files
------------

// File: rtl/mem_access_if.sv
// Wishbone B4 classic data bus between the bexkat1 memory stage (master)
// and data memory (slave).
interface mem_access_if #(
  parameter int AW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-3:0] adr;
  logic [31:0]   wrDat;
  logic [31:0]   rdDat;
  logic          ack;
  logic          err;

  modport master (
    output cyc, stb, we, sel, adr, wrDat,
    input  rdDat, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, wrDat,
    output rdDat, ack, err
  );
endinterface

// File: rtl/mem_access.sv
// bexkat1 memory stage: one Wishbone transaction per load/store/push/pop or
// exception entry, stalling execute until the bus completes.
module mem_access #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  input  logic [1:0]  sp_write_i,
  input  logic [31:0] sp_data_i,
  input  logic        exc_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic        pc_set_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic [1:0]  sp_write_o,
  output logic [31:0] sp_data_o,
  output logic        fault_o,
  mem_access_if.master bus
);

  // Instruction type codes shared with the rest of the bexkat1 pipeline.
  localparam logic [3:0] T_PUSH  = 4'h1;
  localparam logic [3:0] T_POP   = 4'h2;
  localparam logic [3:0] T_LOAD  = 4'ha;
  localparam logic [3:0] T_STORE = 4'hb;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          rts_q, rts_d;
  logic          fault_q, fault_d;

  logic [63:0] outIr_q, outIr_d;
  logic [31:0] outPc_q, outPc_d;
  logic        outPcSet_q, outPcSet_d;
  logic [31:0] outResult_q, outResult_d;
  logic [1:0]  outRegWrite_q, outRegWrite_d;
  logic [1:0]  outSpWrite_q, outSpWrite_d;
  logic [31:0] outSpData_q, outSpData_d;
  logic        outFault_q, outFault_d;

  logic [3:0]  opType, opCode;
  logic        isMem, isRts, reqWe, misalign;
  logic [31:0] reqAdr, reqDat, reqWdat, loadVal;
  logic [1:0]  reqSize;
  logic [3:0]  reqSel;
  logic        stallReq;

  assign opType = ir_i[31:28];
  assign opCode = ir_i[27:24];

  // Decode the request; exception entry overrides whatever the ir says.
  always_comb begin
    isMem   = 1'b0;
    isRts   = 1'b0;
    reqWe   = 1'b0;
    reqAdr  = result_i;
    reqDat  = reg_data1_i;
    reqSize = SZ_WORD;
    if (exc_i) begin
      isMem  = 1'b1;
      reqWe  = 1'b1;
      reqAdr = sp_data_i;
      reqDat = pc_i;
    end else begin
      case (opType)
        T_LOAD: begin
          isMem   = 1'b1;
          reqSize = (opCode[1:0] == 2'd3) ? SZ_WORD : opCode[1:0];
        end
        T_STORE: begin
          isMem   = 1'b1;
          reqWe   = 1'b1;
          reqSize = (opCode[1:0] == 2'd3) ? SZ_WORD : opCode[1:0];
        end
        T_PUSH: begin
          isMem  = 1'b1;
          reqWe  = 1'b1;
          reqAdr = sp_data_i;
          reqDat = (opCode == 4'h0) ? reg_data1_i : pc_i;
        end
        T_POP: begin
          isMem  = 1'b1;
          isRts  = (opCode != 4'h0);
          reqAdr = sp_data_i - 32'd4;
        end
        default: ;
      endcase
    end
  end

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    reqSel   = 4'b1111;
    reqWdat  = reqDat;
    misalign = 1'b0;
    case (reqSize)
      SZ_HALF: begin
        reqSel   = reqAdr[1] ? 4'b0011 : 4'b1100;
        reqWdat  = {2{reqDat[15:0]}};
        misalign = reqAdr[0];
      end
      SZ_BYTE: begin
        reqSel  = 4'b1000 >> reqAdr[1:0];
        reqWdat = {4{reqDat[7:0]}};
      end
      default: misalign = (reqAdr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    loadVal = rdat_q;
    case (size_q)
      SZ_HALF: loadVal = adr_q[1] ? {16'h0, rdat_q[15:0]} : {16'h0, rdat_q[31:16]};
      SZ_BYTE: begin
        case (adr_q[1:0])
          2'd0:    loadVal = {24'h0, rdat_q[31:24]};
          2'd1:    loadVal = {24'h0, rdat_q[23:16]};
          2'd2:    loadVal = {24'h0, rdat_q[15:8]};
          default: loadVal = {24'h0, rdat_q[7:0]};
        endcase
      end
      default: loadVal = rdat_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    adr_d         = adr_q;
    wdat_d        = wdat_q;
    rdat_d        = rdat_q;
    sel_d         = sel_q;
    we_d          = we_q;
    size_d        = size_q;
    rts_d         = rts_q;
    fault_d       = fault_q;
    outIr_d       = outIr_q;
    outPc_d       = outPc_q;
    outPcSet_d    = outPcSet_q;
    outResult_d   = outResult_q;
    outRegWrite_d = outRegWrite_q;
    outSpWrite_d  = outSpWrite_q;
    outSpData_d   = outSpData_q;
    outFault_d    = 1'b0;
    stallReq      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (isMem) begin
          stallReq = 1'b1;
          if (!stall_i) begin
            adr_d   = reqAdr;
            wdat_d  = reqWdat;
            sel_d   = reqSel;
            we_d    = reqWe;
            size_d  = reqSize;
            rts_d   = isRts;
            fault_d = misalign;
            state_d = misalign ? DONE : REQ;
          end
        end else if (!stall_i) begin
          outIr_d       = ir_i;
          outPc_d       = pc_i;
          outPcSet_d    = 1'b0;
          outResult_d   = result_i;
          outRegWrite_d = reg_write_i;
          outSpWrite_d  = sp_write_i;
          outSpData_d   = sp_data_i;
        end
      end
      REQ: begin
        stallReq = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (bus.err) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else if (bus.ack) begin
          rdat_d  = bus.rdDat;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!stall_i) begin
          outIr_d      = ir_i;
          outPc_d      = pc_i;
          outPcSet_d   = 1'b0;
          outSpWrite_d = sp_write_i;
          outSpData_d  = sp_data_i;
          outFault_d   = fault_q;
          if (fault_q) begin
            outResult_d   = 32'h0;
            outRegWrite_d = 2'b00;
          end else begin
            outRegWrite_d = reg_write_i;
            outResult_d   = result_i;
            if (!we_q && rts_q) begin
              outPc_d    = loadVal;
              outPcSet_d = 1'b1;
            end else if (!we_q) begin
              outResult_d = loadVal;
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      adr_q         <= 32'h0;
      wdat_q        <= 32'h0;
      rdat_q        <= 32'h0;
      sel_q         <= 4'h0;
      we_q          <= 1'b0;
      size_q        <= SZ_WORD;
      rts_q         <= 1'b0;
      fault_q       <= 1'b0;
      outIr_q       <= 64'h0;
      outPc_q       <= 32'h0;
      outPcSet_q    <= 1'b0;
      outResult_q   <= 32'h0;
      outRegWrite_q <= 2'b00;
      outSpWrite_q  <= 2'b00;
      outSpData_q   <= 32'h0;
      outFault_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      adr_q         <= adr_d;
      wdat_q        <= wdat_d;
      rdat_q        <= rdat_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      size_q        <= size_d;
      rts_q         <= rts_d;
      fault_q       <= fault_d;
      outIr_q       <= outIr_d;
      outPc_q       <= outPc_d;
      outPcSet_q    <= outPcSet_d;
      outResult_q   <= outResult_d;
      outRegWrite_q <= outRegWrite_d;
      outSpWrite_q  <= outSpWrite_d;
      outSpData_q   <= outSpData_d;
      outFault_q    <= outFault_d;
    end
  end

  // Stall is held low while in reset so every output reads zero.
  assign stall_o     = stallReq & rst_i;
  assign ir_o        = outIr_q;
  assign pc_o        = outPc_q;
  assign pc_set_o    = outPcSet_q;
  assign result_o    = outResult_q;
  assign reg_write_o = outRegWrite_q;
  assign sp_write_o  = outSpWrite_q;
  assign sp_data_o   = outSpData_q;
  assign fault_o     = outFault_q;

  assign bus.cyc   = (state_q == REQ);
  assign bus.stb   = (state_q == REQ);
  assign bus.we    = we_q;
  assign bus.sel   = sel_q;
  assign bus.adr   = adr_q[AW-1:2];
  assign bus.wrDat = wdat_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table through a scoreboard queue,
// plus hand sequences for downstream stalls and reset during a bus cycle.
module tb_mem_access;

  localparam int TO = 255;
  localparam logic [3:0] T_ALU   = 4'h7;
  localparam logic [3:0] T_PUSH  = 4'h1;
  localparam logic [3:0] T_POP   = 4'h2;
  localparam logic [3:0] T_LOAD  = 4'ha;
  localparam logic [3:0] T_STORE = 4'hb;
  localparam int NV = 18;

  typedef struct {
    logic [63:0] ir;
    logic [31:0] pc, result, data1, spData;
    logic [1:0]  regW, spW;
    logic        exc;
    int          mode, delay;
    logic [31:0] rdata;
    logic [31:0] eResult, ePc;
    logic        ePcSet, eFault, eWe;
    logic [1:0]  eRegW;
    int          eStall, eTxn;
    logic [29:0] eAdr;
    logic [3:0]  eSel;
    logic [31:0] eDat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] ir;
  logic [31:0] pc, result, data1, spData;
  logic [1:0]  regW, spW;
  logic        exc, stallIn;

  logic        stallO, pcSetO, faultO;
  logic [63:0] irO;
  logic [31:0] pcO, resultO, spDataO;
  logic [1:0]  regWriteO, spWriteO;

  int passCount = 0;
  int totalCount = 0;

  // Bus slave configuration: 0 ack, 1 err, 2 silent, 3 ack and err together
  int          slvMode = 2;
  int          slvDelay = 1;
  logic [31:0] slvData = 32'h0;
  int          reqCnt = 0;
  int          txnCount = 0;
  logic [29:0] capAdr;
  logic [3:0]  capSel;
  logic        capWe;
  logic [31:0] capDat;

  vec_t tbl[NV];
  vec_t expQ[$];

  mem_access_if #(.AW(32)) bus ();

  mem_access #(.TIMEOUT(TO), .AW(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .ir_i        (ir),
    .pc_i        (pc),
    .result_i    (result),
    .reg_data1_i (data1),
    .reg_write_i (regW),
    .sp_write_i  (spW),
    .sp_data_i   (spData),
    .exc_i       (exc),
    .stall_i     (stallIn),
    .stall_o     (stallO),
    .ir_o        (irO),
    .pc_o        (pcO),
    .pc_set_o    (pcSetO),
    .result_o    (resultO),
    .reg_write_o (regWriteO),
    .sp_write_o  (spWriteO),
    .sp_data_o   (spDataO),
    .fault_o     (faultO),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reqCnt <= 0;
    else if (bus.cyc && bus.stb) reqCnt <= reqCnt + 1;
    else reqCnt <= 0;
  end

  always @(negedge clk) begin
    if (bus.cyc && bus.stb) begin
      if (reqCnt == 0) begin
        txnCount <= txnCount + 1;
        capAdr   <= bus.adr;
        capSel   <= bus.sel;
        capWe    <= bus.we;
        capDat   <= bus.wrDat;
      end
      bus.ack   <= (slvMode == 0 || slvMode == 3) && (reqCnt == slvDelay - 1);
      bus.err   <= (slvMode == 1 || slvMode == 3) && (reqCnt == slvDelay - 1);
      bus.rdDat <= slvData;
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act !== exp) $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    else passCount++;
  endtask

  function automatic vec_t mkIn(input logic [3:0] t, input logic [3:0] op,
                                input logic [31:0] p, input logic [31:0] r,
                                input logic [31:0] d1, input logic [31:0] sp,
                                input logic [1:0] rw, input logic [1:0] sw,
                                input logic ex);
    vec_t v;
    v.ir      = {p ^ 32'h5a5a0000, t, op, 24'h000123};
    v.pc      = p;
    v.result  = r;
    v.data1   = d1;
    v.spData  = sp;
    v.regW    = rw;
    v.spW     = sw;
    v.exc     = ex;
    v.mode    = 2;
    v.delay   = 1;
    v.rdata   = 32'h0;
    v.eResult = r;
    v.ePc     = p;
    v.ePcSet  = 1'b0;
    v.eFault  = 1'b0;
    v.eRegW   = rw;
    v.eStall  = 0;
    v.eTxn    = 0;
    v.eAdr    = 30'h0;
    v.eSel    = 4'h0;
    v.eWe     = 1'b0;
    v.eDat    = 32'h0;
    return v;
  endfunction

  function automatic vec_t mkBus(input vec_t vi, input int m, input int dly,
                                 input logic [31:0] rd, input logic [29:0] a,
                                 input logic [3:0] s, input logic w, input logic [31:0] d);
    vec_t v = vi;
    v.mode   = m;
    v.delay  = dly;
    v.rdata  = rd;
    v.eTxn   = 1;
    v.eStall = (m == 2) ? 1 + TO : 1 + dly;
    v.eAdr   = a;
    v.eSel   = s;
    v.eWe    = w;
    v.eDat   = d;
    return v;
  endfunction

  function automatic vec_t mkFault(input vec_t vi);
    vec_t v = vi;
    v.eFault  = 1'b1;
    v.eResult = 32'h0;
    v.eRegW   = 2'b00;
    v.ePcSet  = 1'b0;
    return v;
  endfunction

  task automatic fillTable();
    tbl[0]  = mkIn(T_ALU, 4'h0, 32'h1000, 32'h12345678, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0);
    tbl[1]  = mkIn(T_ALU, 4'h3, 32'h1004, 32'hffffffff, 32'h0, 32'h7ff0, 2'd2, 2'd3, 1'b0);
    tbl[2]  = mkBus(mkIn(T_LOAD, 4'h0, 32'h1010, 32'h100, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0),
                    0, 3, 32'hdeadbeef, 30'h40, 4'b1111, 1'b0, 32'h0);
    tbl[2].eResult = 32'hdeadbeef;
    tbl[3]  = mkBus(mkIn(T_STORE, 4'h2, 32'h1020, 32'h103, 32'h5a, 32'h8000, 2'd0, 2'd0, 1'b0),
                    0, 1, 32'h0, 30'h40, 4'b0001, 1'b1, 32'h5a5a5a5a);
    tbl[4]  = mkBus(mkIn(T_LOAD, 4'h2, 32'h1024, 32'h101, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0),
                    0, 1, 32'h11223344, 30'h40, 4'b0100, 1'b0, 32'h0);
    tbl[4].eResult = 32'h22;
    tbl[5]  = mkBus(mkIn(T_LOAD, 4'h1, 32'h1028, 32'h102, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0),
                    0, 2, 32'haabbccdd, 30'h40, 4'b0011, 1'b0, 32'h0);
    tbl[5].eResult = 32'hccdd;
    tbl[6]  = mkBus(mkIn(T_STORE, 4'h1, 32'h102c, 32'h100, 32'h1234abcd, 32'h8000, 2'd0, 2'd0, 1'b0),
                    0, 1, 32'h0, 30'h40, 4'b1100, 1'b1, 32'habcdabcd);
    tbl[7]  = mkBus(mkIn(T_PUSH, 4'h1, 32'h2000, 32'h7ff8, 32'h0, 32'h7ffc, 2'd0, 2'd1, 1'b0),
                    0, 1, 32'h0, 30'h1fff, 4'b1111, 1'b1, 32'h2000);
    tbl[8]  = mkBus(mkIn(T_POP, 4'h1, 32'h2100, 32'h8004, 32'h0, 32'h8000, 2'd0, 2'd1, 1'b0),
                    0, 2, 32'h2000, 30'h1fff, 4'b1111, 1'b0, 32'h0);
    tbl[8].ePc    = 32'h2000;
    tbl[8].ePcSet = 1'b1;
    tbl[9]  = mkBus(mkIn(T_POP, 4'h0, 32'h2200, 32'h8004, 32'h0, 32'h8000, 2'd1, 2'd1, 1'b0),
                    0, 1, 32'h55, 30'h1fff, 4'b1111, 1'b0, 32'h0);
    tbl[9].eResult = 32'h55;
    tbl[10] = mkBus(mkIn(T_PUSH, 4'h0, 32'h2300, 32'h6ffc, 32'ha5a5, 32'h7000, 2'd0, 2'd1, 1'b0),
                    0, 2, 32'h0, 30'h1c00, 4'b1111, 1'b1, 32'ha5a5);
    tbl[11] = mkFault(mkBus(mkIn(T_LOAD, 4'h0, 32'h2400, 32'h200, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0),
                            1, 2, 32'h12345678, 30'h80, 4'b1111, 1'b0, 32'h0));
    tbl[12] = mkFault(mkBus(mkIn(T_LOAD, 4'h0, 32'h2404, 32'h204, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0),
                            3, 1, 32'h12345678, 30'h81, 4'b1111, 1'b0, 32'h0));
    tbl[13] = mkFault(mkIn(T_LOAD, 4'h1, 32'h2408, 32'h101, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0));
    tbl[13].eStall = 1;
    tbl[14] = mkFault(mkIn(T_STORE, 4'h0, 32'h240c, 32'h102, 32'h77, 32'h8000, 2'd0, 2'd0, 1'b0));
    tbl[14].eStall = 1;
    tbl[15] = mkBus(mkIn(T_ALU, 4'h0, 32'h3000, 32'h42, 32'h0, 32'h6000, 2'd0, 2'd1, 1'b1),
                    0, 1, 32'h0, 30'h1800, 4'b1111, 1'b1, 32'h3000);
    tbl[16] = mkFault(mkBus(mkIn(T_LOAD, 4'h3, 32'h2500, 32'h300, 32'h0, 32'h8000, 2'd1, 2'd0, 1'b0),
                            2, 1, 32'h0, 30'hc0, 4'b1111, 1'b0, 32'h0));
    tbl[17] = mkIn(T_ALU, 4'h1, 32'h4000, 32'habcd, 32'h0, 32'h5000, 2'd3, 2'd2, 1'b0);
  endtask

  task automatic driveNop();
    ir = 64'h0; pc = 32'h0; result = 32'h0; data1 = 32'h0;
    spData = 32'h0; regW = 2'd0; spW = 2'd0; exc = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    ir = v.ir; pc = v.pc; result = v.result; data1 = v.data1;
    spData = v.spData; regW = v.regW; spW = v.spW; exc = v.exc;
    slvMode = v.mode; slvDelay = v.delay; slvData = v.rdata;
  endtask

  task automatic checkOutput(input int idx, input vec_t e, input int stall, input int txn);
    string p = $sformatf("v%0d.", idx);
    chk({p, "stallCycles"}, stall, e.eStall);
    chk({p, "txnCount"}, txn, e.eTxn);
    chk({p, "result"}, resultO, e.eResult);
    chk({p, "pc"}, pcO, e.ePc);
    chk({p, "pcSet"}, pcSetO, e.ePcSet);
    chk({p, "regWrite"}, regWriteO, e.eRegW);
    chk({p, "fault"}, faultO, e.eFault);
    chk({p, "ir"}, irO, e.ir);
    chk({p, "spWrite"}, spWriteO, e.spW);
    chk({p, "spData"}, spDataO, e.spData);
    if (e.eTxn != 0) begin
      chk({p, "adr"}, capAdr, e.eAdr);
      chk({p, "sel"}, capSel, e.eSel);
      chk({p, "we"}, capWe, e.eWe);
      if (e.eWe) chk({p, "wrDat"}, capDat, e.eDat);
    end
  endtask

  task automatic runVector(input int idx, input vec_t v);
    int stall = 0;
    int txn0 = txnCount;
    vec_t e;
    applyStimulus(v);
    expQ.push_back(v);
    #1;
    while (stallO === 1'b1 && stall < 2 * TO) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 2 * TO) chk($sformatf("v%0d.stallBound", idx), stall, 0);
    @(negedge clk);
    e = expQ.pop_front();
    checkOutput(idx, e, stall, txnCount - txn0);
    driveNop();
    @(negedge clk);
    chk($sformatf("v%0d.faultPulse", idx), faultO, 1'b0);
  endtask

  task automatic seqStallDone();
    int txn0;
    int guard = 0;
    applyStimulus(mkIn(T_ALU, 4'h0, 32'h5000, 32'h77, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0));
    @(negedge clk);
    chk("sd.pre", resultO, 32'h77);
    txn0 = txnCount;
    applyStimulus(mkBus(mkIn(T_LOAD, 4'h0, 32'h5004, 32'h100, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0),
                        0, 1, 32'h0badf00d, 30'h40, 4'hf, 1'b0, 32'h0));
    #1;
    while (stallO === 1'b1 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    chk("sd.reachDone", guard, 2);
    stallIn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("sd.hold%0d.stall", i), stallO, 1'b0);
      chk($sformatf("sd.hold%0d.result", i), resultO, 32'h77);
      chk($sformatf("sd.hold%0d.cyc", i), bus.cyc, 1'b0);
    end
    stallIn = 1'b0;
    @(negedge clk);
    chk("sd.result", resultO, 32'h0badf00d);
    chk("sd.regWrite", regWriteO, 2'd1);
    chk("sd.txn", txnCount - txn0, 1);
    driveNop();
    @(negedge clk);
  endtask

  task automatic seqStallIdle();
    int txn0;
    applyStimulus(mkIn(T_ALU, 4'h0, 32'h6000, 32'h44, 32'h0, 32'h0, 2'd2, 2'd0, 1'b0));
    @(negedge clk);
    chk("si.pre", resultO, 32'h44);
    stallIn = 1'b1;
    applyStimulus(mkIn(T_ALU, 4'h0, 32'h6004, 32'h55, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0));
    repeat (2) @(negedge clk);
    chk("si.holdResult", resultO, 32'h44);
    chk("si.holdPc", pcO, 32'h6000);
    txn0 = txnCount;
    applyStimulus(mkBus(mkIn(T_LOAD, 4'h0, 32'h6008, 32'h100, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0),
                        0, 1, 32'h1, 30'h40, 4'hf, 1'b0, 32'h0));
    repeat (2) @(negedge clk);
    chk("si.noTxn", txnCount - txn0, 0);
    chk("si.noCyc", bus.cyc, 1'b0);
    driveNop();
    stallIn = 1'b0;
    @(negedge clk);
  endtask

  task automatic seqResetReq();
    applyStimulus(mkIn(T_ALU, 4'h0, 32'h7000, 32'h99, 32'h0, 32'h1234, 2'd1, 2'd1, 1'b0));
    @(negedge clk);
    chk("rr.pre", resultO, 32'h99);
    applyStimulus(mkBus(mkIn(T_LOAD, 4'h0, 32'h7004, 32'h100, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0),
                        2, 1, 32'h0, 30'h40, 4'hf, 1'b0, 32'h0));
    repeat (2) @(negedge clk);
    chk("rr.cycBefore", bus.cyc, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr.cycAsync", bus.cyc, 1'b0);
    chk("rr.stbAsync", bus.stb, 1'b0);
    chk("rr.resultAsync", resultO, 32'h0);
    chk("rr.spDataAsync", spDataO, 32'h0);
    chk("rr.stallAsync", stallO, 1'b0);
    driveNop();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr.idleStall", stallO, 1'b0);
    chk("rr.idleCyc", bus.cyc, 1'b0);
    chk("rr.idlePc", pcO, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fillTable();
    driveNop();
    stallIn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.result", resultO, 32'h0);
    chk("reset.ir", irO, 64'h0);
    chk("reset.fault", faultO, 1'b0);
    chk("reset.cyc", bus.cyc, 1'b0);
    applyStimulus(tbl[2]);
    #1;
    chk("reset.stallWithLoad", stallO, 1'b0);
    driveNop();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NV; i++) runVector(i, tbl[i]);
    seqStallDone();
    seqStallIdle();
    seqResetReq();
    runVector(100, tbl[2]);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
